// File: rtl/clk_en_synth.sv
// clk_en_synth: multi-channel phase-accumulator clock-enable generator with
// glitch-free runtime rate changes and a start-up/retune lock indicator.
module clk_en_synth #(
    parameter int unsigned                CHANNELS    = 3,
    parameter int unsigned                ACC_W       = 32,
    parameter logic [CHANNELS*ACC_W-1:0]  INC_INIT    = '0,
    parameter int unsigned                LOCK_CYCLES = 16
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           cfg_wr,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
    input  logic [ACC_W-1:0]                               cfg_inc,
    output logic [CHANNELS-1:0]                            cfg_pending,
    output logic [CHANNELS-1:0]                            ce,
    output logic [CHANNELS-1:0]                            sq,
    output logic                                           locked
);

    localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [15:0] LOCK_MAX = 16'(LOCK_CYCLES);

    // Out-of-range channel numbers match no wr_hit bit, so such writes are ignored.
    logic [CHANNELS-1:0] wr_hit;

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic [ACC_W-1:0] acc_q;
        logic [ACC_W-1:0] inc_q;
        logic [ACC_W-1:0] pend_inc_q;
        logic             pend_q;
        logic             ce_q;
        logic             sq_q;
        logic [ACC_W:0]   sum;
        logic             apply;

        assign wr_hit[n] = cfg_wr && (cfg_ch == CH_W'(n));
        assign sum       = {1'b0, acc_q} + {1'b0, inc_q};
        // Swap rates only on a wrap so the period in flight finishes at the old
        // rate; a stopped channel has no wrap to wait for.
        assign apply     = pend_q && (sum[ACC_W] || (inc_q == '0));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_q      <= '0;
                inc_q      <= INC_INIT[n*ACC_W +: ACC_W];
                pend_inc_q <= '0;
                pend_q     <= 1'b0;
                ce_q       <= 1'b0;
                sq_q       <= 1'b0;
            end else begin
                acc_q <= sum[ACC_W-1:0];
                ce_q  <= sum[ACC_W];
                sq_q  <= sum[ACC_W-1];
                if (apply) begin
                    inc_q <= pend_inc_q;
                end
                if (wr_hit[n]) begin
                    pend_inc_q <= cfg_inc;
                    pend_q     <= 1'b1;
                end else if (apply) begin
                    pend_q <= 1'b0;
                end
            end
        end

        assign cfg_pending[n] = pend_q;
        assign ce[n]          = ce_q;
        assign sq[n]          = sq_q;
    end

    logic [15:0] lock_cnt_q;
    logic        locked_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            if (lock_cnt_q != LOCK_MAX) begin
                lock_cnt_q <= lock_cnt_q + 16'd1;
            end
            locked_q <= (lock_cnt_q == LOCK_MAX) && !(|cfg_pending) && !(|wr_hit);
        end
    end

    assign locked = locked_q;

endmodule

// File: tb/tb_clk_en_synth.sv
// Self-checking bench for clk_en_synth: per-cycle scoreboard against a small
// NCO model, a start-up vector table and hand-derived retune sequences.
module tb_clk_en_synth;

    localparam int NCH = 3;
    localparam int LC  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_wr = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_inc = '0;
    logic [2:0] cfg_pending;
    logic [2:0] ce;
    logic [2:0] sq;
    logic       locked;

    clk_en_synth #(
        .CHANNELS   (3),
        .ACC_W      (8),
        .INC_INIT   (24'h00_40_80),
        .LOCK_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_wr     (cfg_wr),
        .cfg_ch     (cfg_ch),
        .cfg_inc    (cfg_inc),
        .cfg_pending(cfg_pending),
        .ce         (ce),
        .sq         (sq),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [2:0] ce;
        logic [2:0] sq;
        logic [2:0] pend;
        logic       locked;
    } exp_t;
    exp_t sb_q[$];

    // Reference model state
    logic [7:0] m_acc[NCH];
    logic [7:0] m_inc[NCH];
    logic [7:0] m_pinc[NCH];
    logic [2:0] m_pend, m_ce, m_sq;
    logic       m_locked;
    int         m_cnt;

    typedef struct {
        int         k;
        logic [2:0] ce;
        logic [2:0] sq;
        logic       lk;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_acc[0] = 8'h00; m_acc[1] = 8'h00; m_acc[2] = 8'h00;
        m_inc[0] = 8'h80; m_inc[1] = 8'h40; m_inc[2] = 8'h00;
        m_pinc[0] = 8'h00; m_pinc[1] = 8'h00; m_pinc[2] = 8'h00;
        m_pend = '0; m_ce = '0; m_sq = '0; m_locked = 1'b0; m_cnt = 0;
    endtask

    task automatic model_step(input logic wr, input logic [1:0] ch, input logic [7:0] inc);
        logic [8:0] s;
        logic       app;
        logic       lk;
        lk = (m_cnt == LC) && (m_pend == 3'b000) && !(wr && (ch != 2'd3));
        for (int n = 0; n < NCH; n++) begin
            s   = {1'b0, m_acc[n]} + {1'b0, m_inc[n]};
            app = m_pend[n] && (s[8] || (m_inc[n] == 8'h00));
            m_acc[n] = s[7:0];
            m_ce[n]  = s[8];
            m_sq[n]  = s[7];
            if (app) m_inc[n] = m_pinc[n];
            if (wr && (ch == 2'(n))) begin
                m_pinc[n] = inc;
                m_pend[n] = 1'b1;
            end else if (app) begin
                m_pend[n] = 1'b0;
            end
        end
        m_locked = lk;
        if (m_cnt < LC) m_cnt++;
        sb_q.push_back('{ce: m_ce, sq: m_sq, pend: m_pend, locked: m_locked});
    endtask

    // Drive one cycle of stimulus, then compare against the scoreboard just after the edge.
    task automatic cycle(input logic wr, input logic [1:0] ch, input logic [7:0] inc);
        exp_t e;
        cfg_wr  = wr;
        cfg_ch  = ch;
        cfg_inc = inc;
        model_step(wr, ch, inc);
        @(posedge clk);
        #1;
        cyc++;
        cfg_wr = 1'b0;
        e = sb_q.pop_front();
        check("sb ce", 32'(ce), 32'(e.ce));
        check("sb sq", 32'(sq), 32'(e.sq));
        check("sb pending", 32'(cfg_pending), 32'(e.pend));
        check("sb locked", 32'(locked), 32'(e.locked));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 8'h00);
    endtask

    task automatic wait_ce(input int n, output int at);
        at = -1;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (ce[n]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("wait ce timeout", 32'd0, 32'd1);
    endtask

    task automatic run_startup();
        for (int i = 0; i < 8; i++) begin
            int guard = 0;
            while (cyc < tbl[i].k && guard < 64) begin
                idle(1);
                guard++;
            end
            check("start ce", 32'(ce), 32'(tbl[i].ce));
            check("start sq", 32'(sq), 32'(tbl[i].sq));
            check("start locked", 32'(locked), 32'(tbl[i].lk));
        end
    endtask

    initial begin
        int e, e2, e3, cnt, bad, last, pcnt;

        // Cycle k = state after the k-th edge following reset release.
        tbl[0] = '{1,  3'b000, 3'b001, 1'b0};
        tbl[1] = '{2,  3'b001, 3'b010, 1'b0};
        tbl[2] = '{3,  3'b000, 3'b011, 1'b0};
        tbl[3] = '{4,  3'b011, 3'b000, 1'b0};
        tbl[4] = '{5,  3'b000, 3'b001, 1'b0};
        tbl[5] = '{16, 3'b011, 3'b000, 1'b0};
        tbl[6] = '{17, 3'b000, 3'b001, 1'b1};
        tbl[7] = '{18, 3'b001, 3'b010, 1'b1};

        model_reset();
        repeat (3) @(negedge clk);
        check("reset ce", 32'(ce), 32'd0);
        check("reset sq", 32'(sq), 32'd0);
        check("reset pending", 32'(cfg_pending), 32'd0);
        check("reset locked", 32'(locked), 32'd0);
        rst = 1'b0;
        cyc = 0;
        run_startup();
        idle(4);

        // ch1 retuned to 0x55: 85 pulses per 256 cycles, spacing 3 or 4.
        cycle(1'b1, 2'd1, 8'h55);
        idle(20);
        cnt = 0; bad = 0; last = -1;
        for (int i = 0; i < 256; i++) begin
            idle(1);
            if (ce[1]) begin
                cnt++;
                if (last >= 0 && (cyc - last != 3) && (cyc - last != 4)) bad++;
                last = cyc;
            end
        end
        check("ch1 count", 32'(cnt), 32'd85);
        check("ch1 spacing", 32'(bad), 32'd0);

        // ch0 0x80 -> 0x40 one cycle after a pulse.
        wait_ce(0, e);
        check("p3 locked before", 32'(locked), 32'd1);
        cycle(1'b1, 2'd0, 8'h40);
        check("p3 pending set", 32'(cfg_pending[0]), 32'd1);
        check("p3 locked drop", 32'(locked), 32'd0);
        idle(1);
        check("p3 old-rate ce", 32'(ce[0]), 32'd1);
        check("p3 old-rate gap", 32'(cyc - e), 32'd2);
        check("p3 pending clear", 32'(cfg_pending[0]), 32'd0);
        check("p3 locked still low", 32'(locked), 32'd0);
        e = cyc;
        idle(1);
        check("p3 locked recover", 32'(locked), 32'd1);
        wait_ce(0, e2);
        check("p3 new gap", 32'(e2 - e), 32'd4);

        // Write to nonexistent channel 3 is ignored.
        cycle(1'b1, 2'd3, 8'h11);
        check("p4 pending", 32'(cfg_pending), 32'd0);
        check("p4 locked", 32'(locked), 32'd1);
        idle(8);

        // Idle ch2 started at 0x80.
        cycle(1'b1, 2'd2, 8'h80);
        check("p5 pending set", 32'(cfg_pending[2]), 32'd1);
        idle(1);
        check("p5 pending clear", 32'(cfg_pending[2]), 32'd0);
        idle(1);
        check("p5 ce +1", 32'(ce[2]), 32'd0);
        idle(1);
        check("p5 ce +2", 32'(ce[2]), 32'd1);
        idle(1);
        check("p5 ce +3", 32'(ce[2]), 32'd0);
        idle(1);
        check("p5 ce +4", 32'(ce[2]), 32'd1);

        // Back-to-back writes to ch0 (at 0x40): last write wins.
        wait_ce(0, e);
        pcnt = 0;
        cycle(1'b1, 2'd0, 8'h10);
        pcnt += int'(cfg_pending[0]);
        cycle(1'b1, 2'd0, 8'h20);
        pcnt += int'(cfg_pending[0]);
        idle(1);
        pcnt += int'(cfg_pending[0]);
        idle(1);
        pcnt += int'(cfg_pending[0]);
        check("p6 wrap ce", 32'(ce[0]), 32'd1);
        check("p6 pending cycles", 32'(pcnt), 32'd3);
        e = cyc;
        wait_ce(0, e2);
        check("p6 gap 1", 32'(e2 - e), 32'd8);
        wait_ce(0, e3);
        check("p6 gap 2", 32'(e3 - e2), 32'd8);

        // Asynchronous reset between clock edges.
        check("p7 locked before", 32'(locked), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("p7 async ce", 32'(ce), 32'd0);
        check("p7 async sq", 32'(sq), 32'd0);
        check("p7 async pending", 32'(cfg_pending), 32'd0);
        check("p7 async locked", 32'(locked), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        run_startup();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
